miriscv_irq_ctrl: RTL and testbench
===================================

# miriscv_irq_ctrl

Parametrised multi-line interrupt controller for the miriscv core. Accepts `N_IRQ` request lines, each configured as level- or edge-triggered. Arbitrates among them by fixed lowest-index priority, gated by per-line and global enables. Produces the trap request, the mcause value and the return handshake consumed by the core's trap/mret PC logic and CSR block. Allows one interrupt in service at a time, with no nesting.

## Interface
- `N_IRQ`, 16, number of request lines (1..32)
- `MCAUSE_IRQ_BASE`, 16, cause code of line 0; line k reports `MCAUSE_IRQ_BASE + k`
- `EDGE_MASK`, all-zero `N_IRQ` bits, bit k = 1 makes line k rising-edge-triggered, 0 makes it level-triggered
- `clk_i`  in  1  clock
- `arstn_i`  in  1  reset: asynchronous, active-high
- `irq_req_i`  in  `N_IRQ`  raw request lines, already synchronous to `clk_i`
- `mie_i`  in  `N_IRQ`  per-line enable (from CSR mie)
- `mstatus_mie_i`  in  1  global interrupt enable
- `exception_i`  in  1  synchronous exception in the current instruction
- `stall_i`  in  1  core stall; no trap and no return are accepted while high
- `mret_i`  in  1  current instruction is mret
- `irq_o`  out  1  take interrupt trap this cycle
- `irq_cause_o`  out  32  mcause value
- `irq_ack_o`  out  `N_IRQ`  one-hot acknowledge of the accepted line
- `irq_ret_o`  out  1  mret retires the in-service interrupt
- `busy_o`  out  1  an interrupt is in service

## Operation
- **Edge lines.**
  - `prev_q` registers `irq_req_i`.
  - A rising edge (`irq_req_i & ~prev_q`) sets `pend_q[k]`.
  - `pend_q[k]` is cleared on the edge where line k is acked.
  - If a set and a clear hit the same cycle, the set wins.
- **Level lines.** `pending[k] = irq_req_i[k]`, taken combinationally. There is no storage, and the device must hold the level until serviced.
- **Eligibility.** `eligible = pending & mie_i`.
  - A masked edge pending is retained.
  - It is taken once `mie_i[k]` rises.
- **States.** IDLE and IN_SERVICE.
- **Taking an interrupt (IDLE).** Conditions: `|eligible`, `mstatus_mie_i`, `!exception_i` and `!stall_i`.
  - Select the winner: the lowest index k.
  - Assert `irq_o`.
  - Assert `irq_ack_o = 1<<k`.
  - Drive `irq_cause_o = {1'b1, 31'(MCAUSE_IRQ_BASE+k)}`.
  - Latch the cause into `cause_q`.
  - Move to IN_SERVICE on the next edge.
- **Exception priority.** `exception_i` suppresses `irq_o` and `irq_ack_o` for that cycle; pendings are unchanged.
- **IN_SERVICE.**
  - `irq_o = 0` and `irq_ack_o = 0` regardless of requests.
  - `irq_cause_o = cause_q`.
  - `busy_o = 1`.
- **Return.** `mret_i && !stall_i` in IN_SERVICE asserts `irq_ret_o` combinationally and moves to IDLE on the next edge.
  - `mret_i` in IDLE (exception return) gives `irq_ret_o = 0`.
- **Back-to-back.** A new interrupt is accepted at the earliest in the first IDLE cycle after the return edge.
- **Outside a trap cycle in IDLE**, `irq_cause_o = cause_q`, which holds the last taken cause.

## Timing
- Request to `irq_o`:
  - level line: 0 cycles (combinational)
  - edge line: 1 cycle (edge registered into `pend_q`)
- `irq_o`, `irq_ack_o` and `irq_ret_o` are single-cycle and combinational from registered state plus the current-cycle inputs.
- State, `pend_q` and `cause_q` update on the rising `clk_i` edge.
- **Reset (asynchronous, `arstn_i` high):**
  - state IDLE
  - `pend_q = 0`, `prev_q = 0`, `cause_q = 0`
  - outputs `irq_o = 0`, `irq_ack_o = 0`, `irq_ret_o = 0`, `busy_o = 0`, `irq_cause_o = 0`
  - A line held high through reset release is seen as an edge on the first cycle after release.
  - Reset during IN_SERVICE drops the service without `irq_ret_o`.
- **`stall_i` high.** No accept and no return; edge detection and pending latching continue.

## Structure
- **Package `miriscv_irq_pkg`:**
  - state enum `irq_state_t` {IRQ_IDLE, IRQ_IN_SERVICE}
  - `MCAUSE_INT_BIT = 31`
  - function `irq_cause(idx, base)` returning the 32-bit mcause
- **Sub-module `irq_prio_enc`:** parametrised `N`, input vector; outputs `valid`, one-hot `grant` and binary `idx` (lowest index wins).
- This controller replaces the single-line interrupt controller in the core top. The core keeps the rule that exception cause 2 overrides.

## Test plan
All scenarios use `N_IRQ=16`, `MCAUSE_IRQ_BASE=16`, `EDGE_MASK=16'h00F0`.
- **Level take:** `mie_i=16'hFFFF`, `mstatus_mie_i=1`, `irq_req_i[3]=1` → same-cycle `irq_o=1`, `irq_ack_o=16'h0008`, `irq_cause_o=32'h8000_0013`; next cycle `busy_o=1`, `irq_o=0`.
- **Priority:** `irq_req_i=16'h0A00` → cause `32'h8000_0019` (line 9); after mret and return edge, line 11 taken with cause `32'h8000_001B`.
- **Edge latch while masked:** one-cycle pulse on line 5 with `mie_i[5]=0` → no `irq_o`; raise `mie_i[5]` 10 cycles later → `irq_o=1`, cause `32'h8000_0015`, `pend_q[5]` cleared next edge.
- **Exception and stall gating:**
  - `irq_req_i[0]=1` with `exception_i=1` → `irq_o=0`.
  - With `stall_i=1` → `irq_o=0`.
  - Drop both → `irq_o=1`, cause `32'h8000_0010`.
- **Return handshake:** in IN_SERVICE, `mret_i=1`, `stall_i=1` → `irq_ret_o=0`; `stall_i=0` → `irq_ret_o=1`, `busy_o=0` next cycle; `mret_i` in IDLE → `irq_ret_o=0`.
- **Reset mid-service:** assert `arstn_i` in IN_SERVICE → all outputs 0 immediately (asynchronously); line 4 held high across release → taken 1 cycle after release.

Source files
------------

// File: rtl/miriscv_irq_pkg.sv
// Shared types and helpers for the miriscv multi-line interrupt controller.
package miriscv_irq_pkg;

    typedef enum logic {
        IRQ_IDLE       = 1'b0,
        IRQ_IN_SERVICE = 1'b1
    } irq_state_t;

    localparam int unsigned MCAUSE_INT_BIT = 31;

    // mcause for an interrupt: interrupt flag set, code = base + line index.
    function automatic logic [31:0] irq_cause(input logic [31:0] idx,
                                              input logic [31:0] base);
        logic [31:0] code;
        code                 = base + idx;
        code[MCAUSE_INT_BIT] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
module irq_prio_enc #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        // Walk from the top down so the lowest index is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                grant = '0;
                grant[i] = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Multi-line interrupt controller: edge/level request capture, lowest-index
// arbitration, trap request with mcause, and the mret return handshake.
module miriscv_irq_ctrl
    import miriscv_irq_pkg::*;
#(
    parameter int unsigned          N_IRQ           = 16,
    parameter int unsigned          MCAUSE_IRQ_BASE = 16,
    parameter logic [N_IRQ-1:0]     EDGE_MASK       = '0
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             mstatus_mie_i,
    input  logic             exception_i,
    input  logic             stall_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             irq_ret_o,
    output logic             busy_o
);

    localparam int unsigned IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       state_q, state_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [31:0]      cause_q, cause_d;

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] grant;
    logic [N_IRQ-1:0] ack;
    logic [IW-1:0]    win_idx;
    logic             win_valid;
    logic             take;
    logic             ret;
    logic [31:0]      take_cause;

    // Edge lines come from the sticky pending register, level lines straight
    // from the pins; masked edge pendings stay put until mie_i admits them.
    assign pending  = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
    assign eligible = pending & mie_i;

    irq_prio_enc #(
        .N  (N_IRQ),
        .IW (IW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .grant (grant),
        .idx   (win_idx)
    );

    assign take_cause = irq_cause(32'(win_idx), 32'(MCAUSE_IRQ_BASE));

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        ret     = 1'b0;
        unique case (state_q)
            IRQ_IDLE: begin
                if (win_valid && mstatus_mie_i && !exception_i && !stall_i) begin
                    take    = 1'b1;
                    state_d = IRQ_IN_SERVICE;
                end
            end
            IRQ_IN_SERVICE: begin
                if (mret_i && !stall_i) begin
                    ret     = 1'b1;
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    assign ack     = take ? grant : '0;
    assign cause_d = take ? take_cause : cause_q;
    // A new rising edge outranks the clear from an acknowledge in the same cycle.
    assign pend_d  = (pend_q & ~(ack & EDGE_MASK)) | (irq_req_i & ~prev_q & EDGE_MASK);

    // NOTE: state uses non-blocking assignments and an asynchronous reset so
    // every flop samples the pre-edge values and reset takes effect at once.
    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            state_q <= IRQ_IDLE;
            prev_q  <= '0;
            pend_q  <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_req_i;
            pend_q  <= pend_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are forced quiet while reset is held, even with a level line high.
    assign irq_o       = take & ~arstn_i;
    assign irq_ack_o   = arstn_i ? '0 : ack;
    assign irq_cause_o = arstn_i ? '0 : cause_d;
    assign irq_ret_o   = ret & ~arstn_i;
    assign busy_o      = (state_q == IRQ_IN_SERVICE) & ~arstn_i;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Directed self-checking bench for miriscv_irq_ctrl (N_IRQ=16, base 16, edge lines 4..7).
module tb_miriscv_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [15:0] irq_req_i;
    logic [15:0] mie_i;
    logic        mstatus_mie_i;
    logic        exception_i;
    logic        stall_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ack_o;
    logic        irq_ret_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    miriscv_irq_ctrl #(
        .N_IRQ           (16),
        .MCAUSE_IRQ_BASE (16),
        .EDGE_MASK       (16'h00F0)
    ) dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .irq_req_i     (irq_req_i),
        .mie_i         (mie_i),
        .mstatus_mie_i (mstatus_mie_i),
        .exception_i   (exception_i),
        .stall_i       (stall_i),
        .mret_i        (mret_i),
        .irq_o         (irq_o),
        .irq_cause_o   (irq_cause_o),
        .irq_ack_o     (irq_ack_o),
        .irq_ret_o     (irq_ret_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        arstn_i       = 1'b1;
        irq_req_i     = 16'h0008;
        mie_i         = 16'hFFFF;
        mstatus_mie_i = 1'b1;
        exception_i   = 1'b0;
        stall_i       = 1'b0;
        mret_i        = 1'b0;
        settle();
        check("rst_irq",   32'(irq_o),     32'h0);
        check("rst_ack",   32'(irq_ack_o), 32'h0);
        check("rst_ret",   32'(irq_ret_o), 32'h0);
        check("rst_busy",  32'(busy_o),    32'h0);
        check("rst_cause", irq_cause_o,    32'h0);

        // Level take on line 3.
        tick();
        irq_req_i = 16'h0000;
        tick();
        arstn_i   = 1'b0;
        irq_req_i = 16'h0008;
        settle();
        check("lvl_irq",   32'(irq_o),     32'h1);
        check("lvl_ack",   32'(irq_ack_o), 32'h0008);
        check("lvl_cause", irq_cause_o,    32'h8000_0013);
        tick();
        irq_req_i = 16'h0000;
        settle();
        check("lvl_busy",     32'(busy_o), 32'h1);
        check("lvl_irq_next", 32'(irq_o),  32'h0);
        check("svc_cause",    irq_cause_o, 32'h8000_0013);

        // Return handshake.
        mret_i  = 1'b1;
        stall_i = 1'b1;
        settle();
        check("ret_stalled", 32'(irq_ret_o), 32'h0);
        stall_i = 1'b0;
        settle();
        check("ret_go", 32'(irq_ret_o), 32'h1);
        tick();
        check("ret_busy", 32'(busy_o),    32'h0);
        check("ret_idle", 32'(irq_ret_o), 32'h0);
        mret_i = 1'b0;

        // Priority: lines 9 and 11.
        irq_req_i = 16'h0A00;
        settle();
        check("pri_cause9", irq_cause_o,    32'h8000_0019);
        check("pri_ack9",   32'(irq_ack_o), 32'h0200);
        tick();
        check("pri_noirq_svc", 32'(irq_o), 32'h0);
        mret_i = 1'b1;
        tick();
        mret_i    = 1'b0;
        irq_req_i = 16'h0800;
        settle();
        check("pri_irq11",   32'(irq_o),  32'h1);
        check("pri_cause11", irq_cause_o, 32'h8000_001B);
        tick();
        irq_req_i = 16'h0000;
        mret_i    = 1'b1;
        tick();
        mret_i = 1'b0;

        // Edge on line 5 while masked, admitted later.
        mie_i     = 16'hFFDF;
        irq_req_i = 16'h0020;
        settle();
        check("edg_masked0", 32'(irq_o), 32'h0);
        tick();
        irq_req_i = 16'h0000;
        settle();
        check("edg_masked1", 32'(irq_o), 32'h0);
        for (int i = 0; i < 9; i++) tick();
        check("edg_masked10", 32'(irq_o), 32'h0);
        mie_i = 16'hFFFF;
        settle();
        check("edg_irq",   32'(irq_o),     32'h1);
        check("edg_cause", irq_cause_o,    32'h8000_0015);
        check("edg_ack",   32'(irq_ack_o), 32'h0020);
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        settle();
        check("edg_cleared", 32'(irq_o), 32'h0);

        // Edge latency on line 6, and no retrigger while it stays high.
        irq_req_i = 16'h0040;
        settle();
        check("edg6_same_cycle", 32'(irq_o), 32'h0);
        tick();
        check("edg6_irq",   32'(irq_o),  32'h1);
        check("edg6_cause", irq_cause_o, 32'h8000_0016);
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        settle();
        check("edg6_no_retrig", 32'(irq_o), 32'h0);
        irq_req_i = 16'h0000;

        // Exception and stall gating on line 0.
        irq_req_i   = 16'h0001;
        exception_i = 1'b1;
        settle();
        check("exc_irq",   32'(irq_o),     32'h0);
        check("exc_ack",   32'(irq_ack_o), 32'h0);
        check("exc_cause", irq_cause_o,    32'h8000_0016);
        exception_i = 1'b0;
        stall_i     = 1'b1;
        settle();
        check("stall_irq", 32'(irq_o), 32'h0);
        tick();
        check("stall_busy", 32'(busy_o), 32'h0);
        stall_i = 1'b0;
        settle();
        check("gate_irq",   32'(irq_o),  32'h1);
        check("gate_cause", irq_cause_o, 32'h8000_0010);
        tick();
        irq_req_i = 16'h0000;
        check("gate_busy", 32'(busy_o), 32'h1);

        // Reset mid-service; line 4 held high across release.
        irq_req_i = 16'h0010;
        mret_i    = 1'b1;
        #1;
        arstn_i = 1'b1;
        settle();
        check("mid_rst_busy",  32'(busy_o),      32'h0);
        check("mid_rst_ret",   32'(irq_ret_o),   32'h0);
        check("mid_rst_irq",   32'(irq_o),       32'h0);
        check("mid_rst_cause", irq_cause_o,      32'h0);
        check("mid_rst_ack",   32'(irq_ack_o),   32'h0);
        tick();
        arstn_i = 1'b0;
        mret_i  = 1'b0;
        settle();
        check("rel_irq0", 32'(irq_o), 32'h0);
        tick();
        check("rel_irq1",   32'(irq_o),     32'h1);
        check("rel_cause1", irq_cause_o,    32'h8000_0014);
        check("rel_ack1",   32'(irq_ack_o), 32'h0010);
        tick();
        check("rel_busy", 32'(busy_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
